snn_seq_ctrl: RTL and testbench
===============================

# snn_seq_ctrl

Session controller for the SNN digit classifier. It sits between the UART receiver, the input-image loader, `snn_core` and the UART transmitter, and sequences them through load → classify → report. It gates received bytes into the loader only while an image is being loaded and launches the core exactly once per image. It adds a classification watchdog, drop-and-count handling for bytes that arrive while busy, and a multi-byte ASCII response per image.

## Interface
Parameters:
- `IMG_BYTES`, default 98: bytes per 784-bit image.
- `TIMEOUT_CYC`, default 2**20: cycles allowed between `core_start` and `core_done`.
- `SEND_CRLF`, default 1: append CR, LF after the result character.

Ports:
- `clk` in 1: system clock, 50 MHz.
- `rst_n` in 1: reset, asynchronous, active-low.
- `rx_rdy` in 1: one-cycle pulse, `rx_data` valid.
- `rx_data` in 8: received byte.
- `ld_trigger` out 1: one-cycle byte strobe to the loader.
- `ld_data` out 8: byte to the loader, valid with `ld_trigger`.
- `ld_ready` in 1: one-cycle pulse, loader holds a complete image.
- `core_start` out 1: one-cycle start pulse to `snn_core`.
- `core_done` in 1: one-cycle completion pulse from the core.
- `core_digit` in 4: classification result, valid with `core_done`.
- `tx_start` out 1: one-cycle transmit request.
- `tx_data` out 8: byte to transmit.
- `tx_rdy` in 1: transmitter idle.
- `led` out 8: status display.
- `busy` out 1: high in every state except IDLE.
- `ovr_cnt` out 8: saturating count of dropped rx bytes.

## Operation
- States: IDLE, LOAD, START, CLASSIFY, TX_CHAR, TX_WAIT.
- IDLE:
  - `rx_rdy` → forward the byte, `byte_cnt`=1, go to LOAD.
  - If `IMG_BYTES`==1, the same rules as LOAD apply on the next cycle.
- LOAD:
  - `rx_rdy` with `byte_cnt`<`IMG_BYTES` → forward the byte, `byte_cnt`++.
  - `rx_rdy` with `byte_cnt`==`IMG_BYTES` → drop the byte, `ovr_cnt`++.
  - `ld_ready` → go to START. Set the sticky `fmt_err` if `byte_cnt`≠`IMG_BYTES`.
  - `ld_ready` and `rx_rdy` in the same cycle → START; the byte is dropped and counted.
- START: pulse `core_start`, clear the watchdog, go to CLASSIFY.
- CLASSIFY:
  - `core_done` → latch `core_digit`, go to TX_CHAR.
  - Watchdog reaches `TIMEOUT_CYC`-1 with no `core_done` → set `tmo`, go to TX_CHAR.
  - `core_done` and timeout in the same cycle → `core_done` wins.
- Response sequence: char0, then 0x0D, 0x0A only if `SEND_CRLF`.
  - `fmt_err` → char0 = 'E' (0x45).
  - else `tmo` → char0 = '?' (0x3F).
  - else digit>9 → char0 = '?'.
  - else char0 = 0x30+digit.
- TX_CHAR: wait for `tx_rdy`=1, pulse `tx_start` with the current byte, go to TX_WAIT.
- TX_WAIT:
  - Ignore `tx_rdy` in the first cycle after `tx_start`.
  - Then, on `tx_rdy`=1: if more bytes remain → TX_CHAR, else → IDLE and clear `fmt_err`, `tmo`, `byte_cnt`.
- LED register, updated on entry to TX_CHAR for char0 only:
  - `fmt_err` → 0x40.
  - `tmo` → 0x80.
  - else {4'h0, digit}.
- `rx_rdy` in START, CLASSIFY, TX_CHAR or TX_WAIT → byte dropped, `ovr_cnt`++, saturating at 255.
- `core_done` outside CLASSIFY and `ld_ready` outside LOAD are ignored.

## Timing
- Reset values:
  - State IDLE.
  - `ld_trigger`, `core_start`, `tx_start`, `busy` = 0.
  - `ld_data`, `tx_data`, `led`, `ovr_cnt`, `byte_cnt` = 0.
  - `fmt_err`, `tmo`, watchdog cleared.
- All outputs are registered.
- `ld_trigger`/`ld_data`: cycle N+1 for `rx_rdy` in cycle N.
- `core_start`: cycle N+2 for `ld_ready` in cycle N (START occupies N+1).
- `tx_start`: no earlier than cycle N+2 after `core_done` in cycle N. `tx_data` is stable from the `tx_start` cycle until the next `tx_start`.
- Watchdog: timeout declared exactly `TIMEOUT_CYC` cycles after the `core_start` cycle.
- Reset mid-operation: immediate return to reset values. No partial response is completed.

## Structure
- Package `snn_ctrl_pkg` holds:
  - the state enum `ctrl_state_t`;
  - ASCII constants `ASCII_ZERO`, `ASCII_QMARK`, `ASCII_E`, `ASCII_CR`, `ASCII_LF`;
  - LED codes `LED_TMO`, `LED_FMT`.
- Sub-module `snn_wdog`:
  - clear/enable counter, width `$clog2(TIMEOUT_CYC)`;
  - one-cycle `expired` pulse.
- FSM, byte counter, response sequencer and `ovr_cnt` stay in `snn_seq_ctrl`.
- `byte_cnt` width is `$clog2(IMG_BYTES+1)`.

## Test plan
- Normal image: 98 `rx_rdy` bytes, `ld_ready`, then `core_done` with digit 7 → 98 `ld_trigger` pulses; one `core_start`; tx bytes 0x37, 0x0D, 0x0A; `led`=0x07; `busy` falls after LF.
- Busy overrun: 5 `rx_rdy` pulses during CLASSIFY, then 300 more across later sessions → those 5 bytes are not forwarded, `ovr_cnt`=5; `ovr_cnt` saturates at 255.
- Watchdog: `TIMEOUT_CYC`=64, `core_done` never asserted → tx 0x3F, 0x0D, 0x0A; `led`=0x80; a late `core_done` is ignored.
- Format error: `ld_ready` after 97 bytes → tx 'E'; `led`=0x40; the next clean image reports its digit normally.
- Simultaneous events: `core_done` in the timeout cycle → digit reported. `ld_ready` together with `rx_rdy` → START entered, `ovr_cnt`+1.
- Reset mid-TX_WAIT: `rst_n` low for 1 cycle → all outputs at reset values; no further `tx_start`.

Source files
------------

// File: rtl/snn_ctrl_pkg.sv
// Shared types, ASCII response codes and LED codes for the SNN session controller.
package snn_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      LOAD     = 3'd1,
      START    = 3'd2,
      CLASSIFY = 3'd3,
      TX_CHAR  = 3'd4,
      TX_WAIT  = 3'd5
   } ctrl_state_t;

   localparam logic [7:0] ASCII_ZERO  = 8'h30;
   localparam logic [7:0] ASCII_QMARK = 8'h3F;
   localparam logic [7:0] ASCII_E     = 8'h45;
   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_LF    = 8'h0A;

   localparam logic [7:0] LED_TMO = 8'h80;
   localparam logic [7:0] LED_FMT = 8'h40;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      logic [7:0] r;
      if (v == 8'hFF) r = v;
      else            r = v + 8'd1;
      return r;
   endfunction

   // Format error outranks timeout; out-of-range digits read as unknown.
   function automatic logic [7:0] resp_char(input logic fmt_err, input logic tmo,
                                            input logic [3:0] digit);
      logic [7:0] c;
      if (fmt_err)           c = ASCII_E;
      else if (tmo)          c = ASCII_QMARK;
      else if (digit > 4'd9) c = ASCII_QMARK;
      else                   c = ASCII_ZERO + {4'h0, digit};
      return c;
   endfunction

   function automatic logic [7:0] led_code(input logic fmt_err, input logic tmo,
                                           input logic [3:0] digit);
      logic [7:0] c;
      if (fmt_err)  c = LED_FMT;
      else if (tmo) c = LED_TMO;
      else          c = {4'h0, digit};
      return c;
   endfunction

endpackage

// File: rtl/snn_seq_ctrl_if.sv
// Handshake bundle between the session controller and the UART, loader and core.
interface snn_seq_ctrl_if;
   logic       rx_rdy;
   logic [7:0] rx_data;
   logic       ld_trigger;
   logic [7:0] ld_data;
   logic       ld_ready;
   logic       core_start;
   logic       core_done;
   logic [3:0] core_digit;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       tx_rdy;
   logic [7:0] led;
   logic       busy;
   logic [7:0] ovr_cnt;

   modport master (
      input  rx_rdy, rx_data, ld_ready, core_done, core_digit, tx_rdy,
      output ld_trigger, ld_data, core_start, tx_start, tx_data, led, busy, ovr_cnt
   );

   modport slave (
      output rx_rdy, rx_data, ld_ready, core_done, core_digit, tx_rdy,
      input  ld_trigger, ld_data, core_start, tx_start, tx_data, led, busy, ovr_cnt
   );
endinterface

// File: rtl/snn_wdog.sv
// Classification watchdog: counts enabled cycles after a clear and pulses
// expired once when the count reaches TIMEOUT_CYC-1.
module snn_wdog #(
   parameter int TIMEOUT_CYC = 2**20
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);
   localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

   logic [CW-1:0] cnt_q;
   logic          fired_q;

   // Counter holds at LAST so the expiry can only fire once per clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= {CW{1'b0}};
         fired_q <= 1'b0;
      end else if (clr_i) begin
         cnt_q   <= {CW{1'b0}};
         fired_q <= 1'b0;
      end else if (en_i) begin
         if (cnt_q != LAST) cnt_q   <= cnt_q + CW'(1);
         else               fired_q <= 1'b1;
      end
   end

   assign expired_o = en_i && !fired_q && (cnt_q == LAST);

endmodule

// File: rtl/snn_seq_ctrl.sv
// Session controller: gates rx bytes into the loader, launches the core once per
// image, and reports the result as an ASCII response over the UART transmitter.
module snn_seq_ctrl
   import snn_ctrl_pkg::*;
#(
   parameter int IMG_BYTES   = 98,
   parameter int TIMEOUT_CYC = 2**20,
   parameter bit SEND_CRLF   = 1'b1
) (
   input  logic          clk,
   input  logic          rst_n,
   snn_seq_ctrl_if.master bus
);
   localparam int BW = $clog2(IMG_BYTES + 1);
   localparam logic [BW-1:0] FULL     = BW'(IMG_BYTES);
   localparam logic [1:0]    LAST_IDX = SEND_CRLF ? 2'd2 : 2'd0;

   ctrl_state_t   state_q;
   logic [BW-1:0] byte_cnt_q;
   logic          fmt_err_q;
   logic          tmo_q;
   logic [3:0]    digit_q;
   logic [1:0]    tx_idx_q;
   logic          tx_first_q;
   logic          ld_trigger_q;
   logic [7:0]    ld_data_q;
   logic          core_start_q;
   logic          tx_start_q;
   logic [7:0]    tx_data_q;
   logic [7:0]    led_q;
   logic          busy_q;
   logic [7:0]    ovr_cnt_q;

   logic [7:0]    tx_data_d;
   logic          drop_s;
   logic          wdog_clr_s;
   logic          wdog_en_s;
   logic          wdog_exp_s;

   assign wdog_clr_s = (state_q == START);
   assign wdog_en_s  = (state_q == CLASSIFY);

   snn_wdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_i     (wdog_clr_s),
      .en_i      (wdog_en_s),
      .expired_o (wdog_exp_s)
   );

   // A byte is dropped when busy, when the image is already full, or when it
   // collides with ld_ready.
   assign drop_s = bus.rx_rdy &&
                   ((state_q inside {START, CLASSIFY, TX_CHAR, TX_WAIT}) ||
                    ((state_q == LOAD) && (bus.ld_ready || !(byte_cnt_q < FULL))));

   // Select the response byte for the current position in the sequence.
   always_comb begin
      tx_data_d = resp_char(fmt_err_q, tmo_q, digit_q);
      case (tx_idx_q)
         2'd1:    tx_data_d = ASCII_CR;
         2'd2:    tx_data_d = ASCII_LF;
         default: tx_data_d = resp_char(fmt_err_q, tmo_q, digit_q);
      endcase
   end

   // Session FSM with all outputs registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         byte_cnt_q   <= {BW{1'b0}};
         fmt_err_q    <= 1'b0;
         tmo_q        <= 1'b0;
         digit_q      <= 4'h0;
         tx_idx_q     <= 2'd0;
         tx_first_q   <= 1'b0;
         ld_trigger_q <= 1'b0;
         ld_data_q    <= 8'h00;
         core_start_q <= 1'b0;
         tx_start_q   <= 1'b0;
         tx_data_q    <= 8'h00;
         led_q        <= 8'h00;
         busy_q       <= 1'b0;
         ovr_cnt_q    <= 8'h00;
      end else begin
         ld_trigger_q <= 1'b0;
         core_start_q <= 1'b0;
         tx_start_q   <= 1'b0;
         if (drop_s) ovr_cnt_q <= sat_inc8(ovr_cnt_q);

         case (state_q)
            IDLE: begin
               if (bus.rx_rdy) begin
                  ld_trigger_q <= 1'b1;
                  ld_data_q    <= bus.rx_data;
                  byte_cnt_q   <= BW'(1);
                  busy_q       <= 1'b1;
                  state_q      <= LOAD;
               end
            end
            LOAD: begin
               if (bus.ld_ready) begin
                  if (byte_cnt_q != FULL) fmt_err_q <= 1'b1;
                  state_q <= START;
               end else if (bus.rx_rdy && (byte_cnt_q < FULL)) begin
                  ld_trigger_q <= 1'b1;
                  ld_data_q    <= bus.rx_data;
                  byte_cnt_q   <= byte_cnt_q + BW'(1);
               end
            end
            START: begin
               core_start_q <= 1'b1;
               state_q      <= CLASSIFY;
            end
            CLASSIFY: begin
               // core_done wins over a watchdog expiry in the same cycle.
               if (bus.core_done) begin
                  digit_q  <= bus.core_digit;
                  led_q    <= led_code(fmt_err_q, 1'b0, bus.core_digit);
                  tx_idx_q <= 2'd0;
                  state_q  <= TX_CHAR;
               end else if (wdog_exp_s) begin
                  tmo_q    <= 1'b1;
                  led_q    <= led_code(fmt_err_q, 1'b1, digit_q);
                  tx_idx_q <= 2'd0;
                  state_q  <= TX_CHAR;
               end
            end
            TX_CHAR: begin
               if (bus.tx_rdy) begin
                  tx_start_q <= 1'b1;
                  tx_data_q  <= tx_data_d;
                  tx_first_q <= 1'b1;
                  state_q    <= TX_WAIT;
               end
            end
            TX_WAIT: begin
               // tx_rdy may still read idle the cycle right after tx_start.
               if (tx_first_q) begin
                  tx_first_q <= 1'b0;
               end else if (bus.tx_rdy) begin
                  if (tx_idx_q != LAST_IDX) begin
                     tx_idx_q <= tx_idx_q + 2'd1;
                     state_q  <= TX_CHAR;
                  end else begin
                     fmt_err_q  <= 1'b0;
                     tmo_q      <= 1'b0;
                     byte_cnt_q <= {BW{1'b0}};
                     busy_q     <= 1'b0;
                     state_q    <= IDLE;
                  end
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.ld_trigger = ld_trigger_q;
   assign bus.ld_data    = ld_data_q;
   assign bus.core_start = core_start_q;
   assign bus.tx_start   = tx_start_q;
   assign bus.tx_data    = tx_data_q;
   assign bus.led        = led_q;
   assign bus.busy       = busy_q;
   assign bus.ovr_cnt    = ovr_cnt_q;

endmodule

// File: tb/tb_snn_seq_ctrl.sv
// Directed bench for snn_seq_ctrl: image sessions, overrun, watchdog, format
// error, simultaneous events and reset during transmission.
module tb_snn_seq_ctrl;
   localparam int IMG = 98;
   localparam int TMO = 64;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #10 clk = ~clk;

   snn_seq_ctrl_if bus();

   snn_seq_ctrl #(.IMG_BYTES(IMG), .TIMEOUT_CYC(TMO), .SEND_CRLF(1'b1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int         vecs = 0;
   int         miss = 0;
   int         ld_cnt = 0;
   int         cs_cnt = 0;
   logic [7:0] ld_xor = 8'h00;
   logic [7:0] tx_q[$];

   // Output monitor sampled on the inactive edge.
   always @(negedge clk) begin
      if (bus.ld_trigger === 1'b1) begin
         ld_cnt <= ld_cnt + 1;
         ld_xor <= ld_xor ^ bus.ld_data;
      end
      if (bus.core_start === 1'b1) cs_cnt <= cs_cnt + 1;
      if (bus.tx_start === 1'b1) tx_q.push_back(bus.tx_data);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         miss++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_rx(input logic [7:0] b);
      bus.rx_rdy  = 1'b1;
      bus.rx_data = b;
      tick();
      bus.rx_rdy  = 1'b0;
   endtask

   task automatic pulse_done(input logic [3:0] d);
      bus.core_done  = 1'b1;
      bus.core_digit = d;
      tick();
      bus.core_done  = 1'b0;
   endtask

   task automatic wait_tx(input int n);
      for (int i = 0; i < 400 && tx_q.size() < n; i++) tick();
      check("tx_count", 32'(tx_q.size()), 32'(n));
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 50 && bus.busy !== 1'b0; i++) tick();
      check("busy_fall", 32'(bus.busy), 32'h0);
   endtask

   task automatic start_image(input int n);
      for (int i = 0; i < n; i++) pulse_rx(8'(i + 1));
      bus.ld_ready = 1'b1;
      tick();
      bus.ld_ready = 1'b0;
      tick();
      check("core_start", 32'(bus.core_start), 32'h1);
   endtask

   task automatic session(input int nbytes, input bit ld_with_rx, input int n_busy_rx,
                          input int done_dly, input logic [3:0] d, input logic [7:0] c0,
                          input logic [7:0] led_exp, input logic [7:0] ovr_exp);
      int         ld0;
      int         cs0;
      int         t0;
      logic [7:0] x0;
      logic [7:0] x;
      logic [7:0] b;
      ld0 = ld_cnt;
      cs0 = cs_cnt;
      t0  = tx_q.size();
      x0  = ld_xor;
      x   = 8'h00;
      for (int i = 0; i < nbytes; i++) begin
         b = 8'(i * 7 + 3);
         x = x ^ b;
         pulse_rx(b);
         if (i == 0) begin
            check("ld_trigger_lat", 32'(bus.ld_trigger), 32'h1);
            check("ld_data", 32'(bus.ld_data), 32'(b));
            check("busy_rise", 32'(bus.busy), 32'h1);
         end
      end
      tick();
      tick();
      check("ld_count", 32'(ld_cnt - ld0), 32'(nbytes));
      check("ld_xor", 32'(ld_xor ^ x0), 32'(x));
      bus.ld_ready = 1'b1;
      if (ld_with_rx) begin
         bus.rx_rdy  = 1'b1;
         bus.rx_data = 8'hAA;
      end
      tick();
      bus.ld_ready = 1'b0;
      bus.rx_rdy   = 1'b0;
      check("core_start_early", 32'(bus.core_start), 32'h0);
      tick();
      check("core_start", 32'(bus.core_start), 32'h1);
      for (int i = 0; i < n_busy_rx; i++) pulse_rx(8'hEE);
      for (int i = n_busy_rx; i < done_dly; i++) tick();
      pulse_done(d);
      check("tx_start_early", 32'(bus.tx_start), 32'h0);
      tick();
      check("tx_start_lat", 32'(bus.tx_start), 32'h1);
      check("tx_data_c0", 32'(bus.tx_data), 32'(c0));
      wait_tx(t0 + 3);
      check("tx_byte0", 32'(tx_q[t0]), 32'(c0));
      check("tx_byte1", 32'(tx_q[t0 + 1]), 32'h0D);
      check("tx_byte2", 32'(tx_q[t0 + 2]), 32'h0A);
      check("led", 32'(bus.led), 32'(led_exp));
      check("ovr_cnt", 32'(bus.ovr_cnt), 32'(ovr_exp));
      check("ld_count_after", 32'(ld_cnt - ld0), 32'(nbytes));
      check("core_start_once", 32'(cs_cnt - cs0), 32'h1);
      wait_idle();
   endtask

   initial begin
      int t0;
      int k;
      int ld0;
      bus.rx_rdy     = 1'b0;
      bus.rx_data    = 8'h00;
      bus.ld_ready   = 1'b0;
      bus.core_done  = 1'b0;
      bus.core_digit = 4'h0;
      bus.tx_rdy     = 1'b1;
      tick();
      tick();
      check("rst_ld_trigger", 32'(bus.ld_trigger), 32'h0);
      check("rst_core_start", 32'(bus.core_start), 32'h0);
      check("rst_tx_start", 32'(bus.tx_start), 32'h0);
      check("rst_busy", 32'(bus.busy), 32'h0);
      check("rst_led", 32'(bus.led), 32'h0);
      check("rst_ovr", 32'(bus.ovr_cnt), 32'h0);
      check("rst_tx_data", 32'(bus.tx_data), 32'h0);
      rst_n = 1'b1;
      tick();

      // Normal image, digit 7.
      session(IMG, 1'b0, 0, 3, 4'd7, 8'h37, 8'h07, 8'd0);
      // Five bytes during CLASSIFY are dropped and counted.
      session(IMG, 1'b0, 5, 10, 4'd3, 8'h33, 8'h03, 8'd5);
      // Short image gives a format error, then a clean image recovers.
      session(IMG - 1, 1'b0, 0, 3, 4'd5, 8'h45, 8'h40, 8'd5);
      session(IMG, 1'b0, 0, 3, 4'd2, 8'h32, 8'h02, 8'd5);
      // ld_ready with rx_rdy, and core_done exactly in the timeout cycle.
      session(IMG, 1'b1, 0, TMO - 1, 4'd9, 8'h39, 8'h09, 8'd6);

      // Watchdog expiry: tx_start lands TMO+1 cycles after core_start.
      start_image(IMG);
      t0 = tx_q.size();
      k = 0;
      while (bus.tx_start !== 1'b1 && k < 200) begin
         tick();
         k++;
      end
      check("wdog_latency", 32'(k), 32'(TMO + 1));
      wait_tx(t0 + 3);
      check("wdog_byte0", 32'(tx_q[t0]), 32'h3F);
      check("wdog_byte1", 32'(tx_q[t0 + 1]), 32'h0D);
      check("wdog_byte2", 32'(tx_q[t0 + 2]), 32'h0A);
      check("wdog_led", 32'(bus.led), 32'h80);
      wait_idle();
      pulse_done(4'd5);
      for (int i = 0; i < 5; i++) tick();
      check("late_done_busy", 32'(bus.busy), 32'h0);
      check("late_done_tx", 32'(tx_q.size()), 32'(t0 + 3));
      check("late_done_led", 32'(bus.led), 32'h80);

      // Saturation while parked in TX_CHAR (ovr_cnt starts at 6).
      start_image(IMG);
      ld0 = ld_cnt;
      t0 = tx_q.size();
      bus.tx_rdy = 1'b0;
      pulse_done(4'd4);
      for (int i = 0; i < 248; i++) pulse_rx(8'h55);
      tick();
      check("ovr_254", 32'(bus.ovr_cnt), 32'd254);
      pulse_rx(8'h55);
      tick();
      check("ovr_255", 32'(bus.ovr_cnt), 32'd255);
      for (int i = 0; i < 51; i++) pulse_rx(8'h55);
      tick();
      check("ovr_sat", 32'(bus.ovr_cnt), 32'd255);
      check("ovr_no_fwd", 32'(ld_cnt - ld0), 32'h0);
      check("tx_held", 32'(tx_q.size()), 32'(t0));
      bus.tx_rdy = 1'b1;
      wait_tx(t0 + 3);
      check("sat_byte0", 32'(tx_q[t0]), 32'h34);
      wait_idle();

      // Reset while in TX_WAIT: everything returns to reset values.
      start_image(IMG);
      pulse_done(4'd1);
      k = 0;
      while (bus.tx_start !== 1'b1 && k < 50) begin
         tick();
         k++;
      end
      check("pre_rst_tx_start", 32'(bus.tx_start), 32'h1);
      bus.tx_rdy = 1'b0;
      tick();
      tick();
      t0 = tx_q.size();
      rst_n = 1'b0;
      #1;
      check("mid_rst_ld_data", 32'(bus.ld_data), 32'h0);
      check("mid_rst_tx_data", 32'(bus.tx_data), 32'h0);
      check("mid_rst_led", 32'(bus.led), 32'h0);
      check("mid_rst_busy", 32'(bus.busy), 32'h0);
      check("mid_rst_ovr", 32'(bus.ovr_cnt), 32'h0);
      check("mid_rst_tx_start", 32'(bus.tx_start), 32'h0);
      tick();
      rst_n = 1'b1;
      bus.tx_rdy = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      check("post_rst_no_tx", 32'(tx_q.size()), 32'(t0));
      check("post_rst_busy", 32'(bus.busy), 32'h0);

      // Digit boundaries after reset: 0 and an out-of-range 12.
      session(IMG, 1'b0, 0, 3, 4'd0, 8'h30, 8'h00, 8'd0);
      session(IMG, 1'b0, 0, 3, 4'd12, 8'h3F, 8'h0C, 8'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end

endmodule
